// File: rtl/estados_pkg.sv
// Shared constants for the estados code lock: state encoding,
// seven-segment patterns and the default five-digit BCD code.
package estados_pkg;

    localparam logic [2:0] S0     = 3'd0;
    localparam logic [2:0] S1     = 3'd1;
    localparam logic [2:0] S2     = 3'd2;
    localparam logic [2:0] S3     = 3'd3;
    localparam logic [2:0] S4     = 3'd4;
    localparam logic [2:0] ABERTO = 3'd5;
    localparam logic [2:0] ERRO   = 3'd6;

    localparam logic [6:0] SEG_S0     = 7'b0111111;
    localparam logic [6:0] SEG_S1     = 7'b0000110;
    localparam logic [6:0] SEG_S2     = 7'b1011011;
    localparam logic [6:0] SEG_S3     = 7'b1001111;
    localparam logic [6:0] SEG_S4     = 7'b1100110;
    localparam logic [6:0] SEG_ABERTO = 7'b1110111;
    localparam logic [6:0] SEG_ERRO   = 7'b1111001;

    localparam logic [19:0] CODE_DEF = 20'h59060;

endpackage

// File: rtl/estados_if.sv
// Bundle of the keypad inputs and lock indicator outputs of estados.
// master drives digits and enter; slave is the lock itself.
interface estados_if;
    logic [3:0] numero;
    logic       insere;
    logic       ledErro;
    logic [6:0] display;

    modport master (
        output numero,
        output insere,
        input  ledErro,
        input  display
    );

    modport slave (
        input  numero,
        input  insere,
        output ledErro,
        output display
    );
endinterface

// File: rtl/estados_seg7.sv
// Seven-segment decode of the lock state, bit order {g,f,e,d,c,b,a}.
module estados_seg7
    import estados_pkg::*;
(
    input  logic [2:0] estado_i,
    output logic [6:0] display_o
);

    always_comb begin
        display_o = SEG_S0;
        case (estado_i)
            S0:      display_o = SEG_S0;
            S1:      display_o = SEG_S1;
            S2:      display_o = SEG_S2;
            S3:      display_o = SEG_S3;
            S4:      display_o = SEG_S4;
            ABERTO:  display_o = SEG_ABERTO;
            ERRO:    display_o = SEG_ERRO;
            default: display_o = SEG_S0;
        endcase
    end

endmodule

// File: rtl/estados.sv
// Five-digit code lock FSM with rising-edge entry detection.
// Define ESTADOS_SYNC_IN_EN to add two-flop input synchronizers.
module estados
    import estados_pkg::*;
#(
    parameter logic [19:0] CODE = CODE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] numero,
    input  logic       insere,
    output logic       ledErro,
    output logic [6:0] display
);

    logic       ins_w;
    logic [3:0] num_w;

`ifdef ESTADOS_SYNC_IN_EN
    logic       ins_s1_q, ins_s2_q;
    logic [3:0] num_s1_q, num_s2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ins_s1_q <= 1'b1;
            ins_s2_q <= 1'b1;
            num_s1_q <= 4'd0;
            num_s2_q <= 4'd0;
        end else begin
            ins_s1_q <= insere;
            ins_s2_q <= ins_s1_q;
            num_s1_q <= numero;
            num_s2_q <= num_s1_q;
        end
    end

    assign ins_w = ins_s2_q;
    assign num_w = num_s2_q;
`else
    assign ins_w = insere;
    assign num_w = numero;
`endif

    // insere_q resets high so a key held through reset is not an entry
    logic insere_q;
    logic pulso;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) insere_q <= 1'b1;
        else       insere_q <= ins_w;
    end

    assign pulso = ins_w & ~insere_q;

    logic [2:0] estado_atual;
    logic [2:0] estado_d;
    logic [3:0] esperado;

    always_comb begin
        esperado = 4'd0;
        case (estado_atual)
            S0:      esperado = CODE[19:16];
            S1:      esperado = CODE[15:12];
            S2:      esperado = CODE[11:8];
            S3:      esperado = CODE[7:4];
            S4:      esperado = CODE[3:0];
            default: esperado = 4'd0;
        endcase
    end

    // S0..S4 encode the count of correct digits, so a hit advances by one
    always_comb begin
        estado_d = estado_atual;
        if (pulso) begin
            case (estado_atual)
                S0, S1, S2, S3, S4:
                    estado_d = (num_w == esperado) ? estado_atual + 3'd1
                                                   : ERRO;
                default:
                    estado_d = estado_atual;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) estado_atual <= S0;
        else       estado_atual <= estado_d;
    end

    assign ledErro = (estado_atual == ERRO);

    estados_seg7 u_seg7 (
        .estado_i  (estado_atual),
        .display_o (display)
    );

endmodule

// File: tb/tb_estados.sv
// Directed self-checking bench for estados, with or without
// ESTADOS_SYNC_IN_EN (response then expected two cycles later).
module tb_estados;

    localparam logic [6:0] D_S0 = 7'b0111111;
    localparam logic [6:0] D_S1 = 7'b0000110;
    localparam logic [6:0] D_S2 = 7'b1011011;
    localparam logic [6:0] D_S3 = 7'b1001111;
    localparam logic [6:0] D_S4 = 7'b1100110;
    localparam logic [6:0] D_A  = 7'b1110111;
    localparam logic [6:0] D_E  = 7'b1111001;

`ifdef ESTADOS_SYNC_IN_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    estados_if bus ();

    estados dut (
        .clk     (clk),
        .reset   (reset),
        .numero  (bus.numero),
        .insere  (bus.insere),
        .ledErro (bus.ledErro),
        .display (bus.display)
    );

    always #5 clk = ~clk;

    int nchk  = 0;
    int nfail = 0;
    logic [6:0] cur;

    task automatic chk(input string tag, input logic [6:0] got,
                       input logic [6:0] exp);
        nchk++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        bus.insere = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk({tag, "_disp"}, bus.display, D_S0);
        chk({tag, "_err"}, {6'd0, bus.ledErro}, 7'd0);
        cur = D_S0;
    endtask

    // one-cycle high pulse, then the bench waits out the latency
    task automatic enter(input logic [3:0] d, input logic [6:0] exp,
                         input string tag);
        logic [6:0] early;
        @(negedge clk);
        bus.numero = d;
        bus.insere = 1'b1;
        @(negedge clk);
        bus.insere = 1'b0;
        early = (LAT == 0) ? exp : cur;
        chk({tag, "_early"}, bus.display, early);
        repeat (LAT) @(negedge clk);
        chk({tag, "_disp"}, bus.display, exp);
        chk({tag, "_err"}, {6'd0, bus.ledErro},
            {6'd0, exp == D_E});
        cur = exp;
        @(negedge clk);
    endtask

    initial begin
        bus.numero = 4'd0;
        bus.insere = 1'b0;
        cur = D_S0;
        @(negedge clk);
        chk("in_reset", bus.display, D_S0);

        do_reset("rst1");

        enter(4'd5, D_S1, "ok1");
        enter(4'd9, D_S2, "ok2");
        enter(4'd0, D_S3, "ok3");
        enter(4'd6, D_S4, "ok4");
        enter(4'd0, D_A,  "ok5");
        enter(4'd3, D_A,  "abs_open");

        do_reset("rst2");
        enter(4'd5, D_S1, "w1");
        enter(4'd3, D_E,  "w2");
        enter(4'd9, D_E,  "w3");
        enter(4'd0, D_E,  "w4");
        do_reset("rst3");

        // held entry counts once
        @(negedge clk);
        bus.numero = 4'd5;
        bus.insere = 1'b1;
        repeat (6) @(negedge clk);
        repeat (LAT) @(negedge clk);
        chk("held_disp", bus.display, D_S1);
        bus.insere = 1'b0;
        cur = D_S1;
        @(negedge clk);
        enter(4'd9, D_S2, "held_next");

        do_reset("rst4");
        enter(4'hF, D_E, "nib_f");

        do_reset("rst5");
        enter(4'd5, D_S1, "a1");
        enter(4'd9, D_S2, "a2");
        enter(4'd0, D_S3, "a3");
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_disp", bus.display, D_S0);
        chk("async_err", {6'd0, bus.ledErro}, 7'd0);
        @(negedge clk);
        reset = 1'b0;
        cur = D_S0;

        // enter held high across reset release is not an entry
        reset = 1'b1;
        bus.numero = 4'd5;
        bus.insere = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2 + LAT) @(negedge clk);
        chk("rel_high", bus.display, D_S0);
        bus.insere = 1'b0;
        @(negedge clk);
        enter(4'd5, D_S1, "rel_then");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule

// File: doc/estados.md
ESTADOS -- requirements
Module: estados

Interface
REQ-001 The module SHALL have parameter CODE, default 20'h59060, five BCD code digits, most significant nibble entered first, each digit 0..9.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 The module SHALL have port numero, input, 4 bits, candidate digit in binary.
REQ-005 The module SHALL have port insere, input, 1 bit, level "enter" request; each low-to-high transition submits numero once.
REQ-006 The module SHALL have port ledErro, output, 1 bit, high while in the error state.
REQ-007 The module SHALL have port display, output, 7 bits, active-high seven-segment pattern, bit order {g,f,e,d,c,b,a}.

Function
REQ-008 The FSM SHALL have seven states: S0, S1, S2, S3, S4 (count of correct digits entered), ABERTO (code complete) and ERRO, with the state register named estado_atual.
REQ-009 An entry pulse SHALL be insere high while a register insere_q holds the previous-cycle insere value of 0; only entry pulses cause transitions.
REQ-010 In Sk (k=0..4), an entry pulse with numero equal to code digit k+1 SHALL move to S(k+1), or from S4 to ABERTO; any other value, including 10..15, SHALL move to ERRO.
REQ-011 ABERTO and ERRO SHALL be absorbing; entry pulses there are ignored, and only reset leaves them.
REQ-012 Without an entry pulse the state SHALL hold, and insere held high for any number of cycles SHALL count as one entry.
REQ-013 The transition SHALL take effect at the clock edge sampling the pulse, and outputs SHALL reflect the new state immediately after that edge (one-edge latency).
REQ-014 ledErro SHALL be 1 exactly in ERRO.
REQ-015 display SHALL be a decode of the state only: S0 0111111, S1 0000110, S2 1011011, S3 1001111, S4 1100110, ABERTO 1110111 ('A'), ERRO 1111001 ('E').
REQ-016 Outputs SHALL be glitch-free Moore functions of estado_atual, registered or decoded directly from the state register.

Reset
REQ-017 Asserting reset SHALL immediately force estado_atual=S0, ledErro=0, display=0111111, independent of clk, including mid-sequence.
REQ-018 Reset SHALL set insere_q to 1, so that insere already high at reset release does not count as an entry.

Configuration
REQ-019 With macro ESTADOS_SYNC_IN_EN defined, insere and numero SHALL each pass through a two-flop synchronizer (reset to insere=1, numero=0) before edge detection, adding exactly two cycles of latency.
REQ-020 With ESTADOS_SYNC_IN_EN undefined, inputs SHALL be used directly, with the latency given in REQ-013.

Structure
REQ-021 Package estados_pkg SHALL hold the state enumeration, the seven segment constants, and the default CODE value.
REQ-022 Segment decoding SHALL sit in one sub-module, estados_seg7 (state in, display out); the FSM, edge detector, and optional synchronizer stay in estados.

Verification
REQ-023 Reset test: reset=1 for 2 cycles, then release with insere=0 -> display=0111111, ledErro=0, state S0.
REQ-024 Correct code: digits 5,9,0,6,0, each with insere high for 1 cycle and low for 1 cycle -> display steps 0000110, 1011011, 1001111, 1100110, 1110111; ledErro stays 0.
REQ-025 Wrong digit: enter 5, then 3 -> ledErro=1, display=1111001; a further 9 or 0 -> still ERRO; reset -> S0.
REQ-026 Held entry: numero=5, insere high for 6 cycles -> state S1 only (display 0000110); dropping and re-raising insere with 9 -> S2.
REQ-027 Absorbing/boundary: after ABERTO, enter 3 -> stays ABERTO with ledErro=0; in S0, numero=4'hF entered -> ERRO; reset asserted asynchronously between clock edges while in S3 -> S0 at once.
REQ-028 Each scenario SHALL be repeated with ESTADOS_SYNC_IN_EN defined, checking the response appears two cycles later.
